// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared shifter op codes and helpers
package shifter_pkg;

    // Op codes shared with the ALU decoder; 3'b101..3'b111 are reserved.
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// rtl/shift_layer.sv - one mux layer of the barrel shifter, fixed distance DIST
// Ports:
//   data   - operand entering this layer
//   op     - operation code (reserved codes pass data through)
//   en     - shift-amount bit for this layer; 0 passes data through
//   result - operand after this layer
module shift_layer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;

    // Pure wiring per bit; each candidate is a fixed permutation of data.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_lo_src
            assign sll_v[i] = data[i-DIST];
        end else begin : g_lo_fill
            assign sll_v[i] = 1'b0;
        end

        if (i + DIST < WIDTH) begin : g_hi_src
            assign srl_v[i] = data[i+DIST];
            assign sra_v[i] = data[i+DIST];
        end else begin : g_hi_fill
            assign srl_v[i] = 1'b0;
            // Earlier SRA layers keep the MSB intact, so this is still the sign.
            assign sra_v[i] = data[WIDTH-1];
        end

        assign rol_v[i] = data[(i - DIST + WIDTH) % WIDTH];
        assign ror_v[i] = data[(i + DIST) % WIDTH];
    end

    always_comb begin
        result = data;
        if (en) begin
            case (op)
                OP_SLL:  result = sll_v;
                OP_SRL:  result = srl_v;
                OP_SRA:  result = sra_v;
                OP_ROL:  result = rol_v;
                OP_ROR:  result = ror_v;
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter with valid/ready handshake
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - request handshake
//   in_data, in_shamt     - operand and shift distance
//   in_op, in_tag         - operation code and sideband tag
//   out_valid/out_ready   - result handshake
//   out_data, out_tag     - result and its tag
//   out_err               - the request used a reserved op code
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int                  WIDTH    = 32,
    parameter int                  SHAMT_W  = $clog2(WIDTH),
    parameter logic [SHAMT_W-1:0]  REG_MASK = 5'b00100,
    parameter int                  TAG_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    // Point k is the input of layer k; point SHAMT_W feeds the output register.
    logic               p_valid [SHAMT_W+1];
    logic               p_ready [SHAMT_W+1];
    logic [WIDTH-1:0]   p_data  [SHAMT_W+1];
    logic [2:0]         p_op    [SHAMT_W+1];
    logic [TAG_W-1:0]   p_tag   [SHAMT_W+1];
    logic [SHAMT_W-1:0] p_shamt [SHAMT_W+1];

    assign p_valid[0] = in_valid;
    assign p_data[0]  = in_data;
    assign p_op[0]    = in_op;
    assign p_tag[0]   = in_tag;
    assign p_shamt[0] = in_shamt;
    assign in_ready   = p_ready[0];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
        logic [WIDTH-1:0] shifted;

        shift_layer #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_layer (
            .data   (p_data[k]),
            .op     (p_op[k]),
            .en     (p_shamt[k][k]),
            .result (shifted)
        );

        if (REG_MASK[k]) begin : g_reg
            logic               v;
            logic [WIDTH-1:0]   d;
            logic [2:0]         o;
            logic [TAG_W-1:0]   t;
            logic [SHAMT_W-1:0] s;

            // Loads whenever it may accept (empty or draining); an invalid
            // upstream simply empties the stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    d <= '0;
                    o <= '0;
                    t <= '0;
                    s <= '0;
                end else if (p_ready[k]) begin
                    v <= p_valid[k];
                    if (p_valid[k]) begin
                        d <= shifted;
                        o <= p_op[k];
                        t <= p_tag[k];
                        s <= p_shamt[k];
                    end
                end
            end

            assign p_ready[k]   = !v || p_ready[k+1];
            assign p_valid[k+1] = v;
            assign p_data[k+1]  = d;
            assign p_op[k+1]    = o;
            assign p_tag[k+1]   = t;
            assign p_shamt[k+1] = s;
        end else begin : g_wire
            assign p_ready[k]   = p_ready[k+1];
            assign p_valid[k+1] = p_valid[k];
            assign p_data[k+1]  = shifted;
            assign p_op[k+1]    = p_op[k];
            assign p_tag[k+1]   = p_tag[k];
            assign p_shamt[k+1] = p_shamt[k];
        end
    end

    assign p_ready[SHAMT_W] = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (p_ready[SHAMT_W]) begin
            out_valid <= p_valid[SHAMT_W];
            if (p_valid[SHAMT_W]) begin
                out_data <= p_data[SHAMT_W];
                out_tag  <= p_tag[SHAMT_W];
                out_err  <= is_reserved(p_op[SHAMT_W]);
            end
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - directed self-checking bench for pipe_shifter
module tb_pipe_shifter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance, REG_MASK 5'b00100, latency 2
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_shamt;
    logic [2:0]  a_in_op;
    logic [3:0]  a_in_tag, a_out_tag;

    // 8-bit instance, REG_MASK 3'b000, latency 1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    logic [2:0]  b_in_op;
    logic [3:0]  b_in_tag, b_out_tag;

    int n_checks = 0;
    int n_fails  = 0;

    pipe_shifter #(.WIDTH(32), .REG_MASK(5'b00100), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_err(a_out_err)
    );

    pipe_shifter #(.WIDTH(8), .REG_MASK(3'b000), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One op through the 32-bit instance with out_ready=1: out_valid must be
    // low one cycle after acceptance and high with the result after two.
    task automatic run32(input string name, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [3:0] tg,
                         input logic [31:0] exp, input logic exp_err);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_op = op; a_in_data = d; a_in_shamt = sh; a_in_tag = tg;
        check({name, " in_ready"}, 64'(a_in_ready), 64'd1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check({name, " out_valid+1"}, 64'(a_out_valid), 64'd0);
        @(negedge clk);
        check({name, " out_valid+2"}, 64'(a_out_valid), 64'd1);
        check({name, " data"}, 64'(a_out_data), 64'(exp));
        check({name, " tag"}, 64'(a_out_tag), 64'(tg));
        check({name, " err"}, 64'(a_out_err), 64'(exp_err));
    endtask

    task automatic run8(input string name, input logic [2:0] op, input logic [7:0] d,
                        input logic [2:0] sh, input logic [7:0] exp);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_op = op; b_in_data = d; b_in_shamt = sh; b_in_tag = 4'h9;
        check({name, " in_ready"}, 64'(b_in_ready), 64'd1);
        @(negedge clk);
        b_in_valid = 1'b0;
        check({name, " out_valid+1"}, 64'(b_out_valid), 64'd1);
        check({name, " data"}, 64'(b_out_data), 64'(exp));
        check({name, " err"}, 64'(b_out_err), 64'd0);
        @(negedge clk);
        check({name, " drained"}, 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0;
        b_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(a_out_valid), 64'd0);
        check("reset out_data", 64'(a_out_data), 64'd0);
        check("reset out_tag", 64'(a_out_tag), 64'd0);
        check("reset out_err", 64'(a_out_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(a_in_ready), 64'd1);

        // Basic function, 32-bit
        run32("sll31", 3'b000, 32'h0000_0001, 5'd31, 4'h1, 32'h8000_0000, 1'b0);
        run32("sra4",  3'b010, 32'h8000_0000, 5'd4,  4'h2, 32'hF800_0000, 1'b0);
        run32("srl4",  3'b001, 32'h8000_0000, 5'd4,  4'h3, 32'h0800_0000, 1'b0);
        run32("ror4",  3'b100, 32'h0000_00F1, 5'd4,  4'h4, 32'h1000_000F, 1'b0);
        run32("rol1",  3'b011, 32'h8000_0001, 5'd1,  4'h5, 32'h0000_0003, 1'b0);
        run32("rol17", 3'b011, 32'h0001_8000, 5'd17, 4'h6, 32'h0000_0003, 1'b0);
        run32("sra31", 3'b010, 32'h4000_0000, 5'd31, 4'h7, 32'h0000_0000, 1'b0);
        run32("rsv5",  3'b101, 32'h1234_5678, 5'd3,  4'h8, 32'h1234_5678, 1'b1);
        run32("rsv7",  3'b111, 32'hCAFE_F00D, 5'd9,  4'h9, 32'hCAFE_F00D, 1'b1);
        run32("id_sll", 3'b000, 32'hA5C3_1E7B, 5'd0, 4'hA, 32'hA5C3_1E7B, 1'b0);
        run32("id_srl", 3'b001, 32'hA5C3_1E7B, 5'd0, 4'hB, 32'hA5C3_1E7B, 1'b0);
        run32("id_sra", 3'b010, 32'hA5C3_1E7B, 5'd0, 4'hC, 32'hA5C3_1E7B, 1'b0);
        run32("id_rol", 3'b011, 32'hA5C3_1E7B, 5'd0, 4'hD, 32'hA5C3_1E7B, 1'b0);
        run32("id_ror", 3'b100, 32'hA5C3_1E7B, 5'd0, 4'hE, 32'hA5C3_1E7B, 1'b0);

        // Backpressure: tags 1,2,3 with out_ready low
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_op = 3'b000; a_in_data = 32'h1; a_in_shamt = 5'd4; a_in_tag = 4'h1;
        @(negedge clk);
        check("bp accept2 ready", 64'(a_in_ready), 64'd1);
        a_in_op = 3'b001; a_in_data = 32'h8000_0000; a_in_shamt = 5'd8; a_in_tag = 4'h2;
        @(negedge clk);
        a_in_op = 3'b011; a_in_data = 32'hF000_0000; a_in_shamt = 5'd4; a_in_tag = 4'h3;
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready low", 64'(a_in_ready), 64'd0);
            check("bp hold valid", 64'(a_out_valid), 64'd1);
            check("bp hold tag", 64'(a_out_tag), 64'd1);
            check("bp hold data", 64'(a_out_data), 64'h10);
            if (i < 2) @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("bp out2 tag", 64'(a_out_tag), 64'd2);
        check("bp out2 data", 64'(a_out_data), 64'h0080_0000);
        @(negedge clk);
        check("bp out3 valid", 64'(a_out_valid), 64'd1);
        check("bp out3 tag", 64'(a_out_tag), 64'd3);
        check("bp out3 data", 64'(a_out_data), 64'h0000_000F);
        @(negedge clk);
        check("bp drained", 64'(a_out_valid), 64'd0);

        // Full-pipeline streaming: accept and deliver every cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_op = 3'b000; a_in_data = 32'h1;
            a_in_shamt = 5'(i); a_in_tag = 4'(i);
            check("stream in_ready", 64'(a_in_ready), 64'd1);
            if (i >= 2) begin
                check("stream tag", 64'(a_out_tag), 64'(i - 2));
                check("stream data", 64'(a_out_data), 64'(32'h1 << (i - 2)));
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        check("stream tag tail", 64'(a_out_tag), 64'd2);
        @(negedge clk);
        check("stream tag last", 64'(a_out_tag), 64'd3);
        @(negedge clk);
        check("stream drained", 64'(a_out_valid), 64'd0);

        // Reset with two ops in flight
        @(negedge clk);
        a_in_valid = 1'b1; a_in_op = 3'b000; a_in_data = 32'h3; a_in_shamt = 5'd1; a_in_tag = 4'h5;
        @(negedge clk);
        a_in_tag = 4'h6;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("pre-reset out_valid", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(a_out_valid), 64'd0);
        check("async reset out_tag", 64'(a_out_tag), 64'd0);
        check("async reset out_data", 64'(a_out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no stale after reset", 64'(a_out_valid), 64'd0);
            check("ready after reset", 64'(a_in_ready), 64'd1);
        end

        // 8-bit, latency 1
        run8("w8 sll7", 3'b000, 8'h01, 3'd7, 8'h80);
        run8("w8 ror4", 3'b100, 8'hF1, 3'd4, 8'h1F);
        run8("w8 sra3", 3'b010, 8'h90, 3'd3, 8'hF2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, is the data width; it SHALL be a power of two from 8 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), is the shift-amount width; it SHALL be derived from WIDTH and never overridden.
REQ-003 Parameter REG_MASK, default 5'b00100, is SHAMT_W bits wide; bit k=1 inserts a pipeline register after mux layer k.
REQ-004 Parameter TAG_W, default 4, is the width of the sideband tag carried alongside each operation.
REQ-005 Ports SHALL be:
  - clk  input  1  rising-edge clock
  - rst_n  input  1  asynchronous active-low reset
  - in_valid  input  1  request valid
  - in_ready  output  1  request accepted when high with in_valid
  - in_data  input  WIDTH  operand
  - in_shamt  input  SHAMT_W  shift distance
  - in_op  input  3  operation code
  - in_tag  input  TAG_W  sideband tag
  - out_valid  output  1  result valid
  - out_ready  input  1  consumer accepts
  - out_data  output  WIDTH  result
  - out_tag  output  TAG_W  tag of the result
  - out_err  output  1  reserved op code seen

Function
REQ-006 Op codes SHALL be: 000 SLL, 001 SRL, 010 SRA (sign fill), 011 ROL, 100 ROR; 101-111 are reserved.
REQ-007 A reserved op SHALL return in_data unchanged with out_err=1; all valid ops return out_err=0.
REQ-008 The datapath SHALL be SHAMT_W mux layers; layer k shifts by 2^k when in_shamt[k]=1.
REQ-009 Vacated bits SHALL be 0 for SLL and SRL, in_data[WIDTH-1] for SRA, and the wrapped bits for ROL and ROR.
REQ-010 in_shamt=0 SHALL give an identity result for every op.
REQ-011 An output register SHALL always be present; latency from acceptance to out_valid SHALL be 1+popcount(REG_MASK) cycles when out_ready=1.
REQ-012 Transfers SHALL occur only on cycles where valid and ready are both high, at either port.
REQ-013 Each stage SHALL hold a valid bit; a stage loads when it is empty or when its downstream stage advances in the same cycle.
REQ-014 in_ready SHALL equal "first stage empty or first stage advancing"; the ready chain may be combinational.
REQ-015 Throughput SHALL be one operation per cycle with no bubbles while out_ready=1.
REQ-016 In-flight capacity SHALL equal the latency; results SHALL leave in acceptance order, with no loss and no duplication.
REQ-017 While out_valid=1 and out_ready=0, out_data, out_tag and out_err SHALL be held stable.
REQ-018 Acceptance and delivery in the same cycle with a full pipeline SHALL be supported without a stall.
REQ-019 The op, tag and remaining shamt bits SHALL travel through every pipeline register with the data.

Reset
REQ-020 rst_n low SHALL immediately clear all stage valid bits, out_valid, out_data, out_tag and out_err to 0.
REQ-021 Operations in flight when reset asserts SHALL be discarded; no stale result SHALL appear after reset is released.
REQ-022 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-023 The op-code localparams (OP_SLL..OP_ROR) SHALL live in the shared package shifter_pkg, for reuse by the ALU decoder.
REQ-024 One sub-module, shift_layer (parameters WIDTH and DIST), SHALL implement a single mux layer for all five ops; it is instantiated SHAMT_W times through a generate loop.
REQ-025 The datapath SHALL contain no behavioural shift operators, keeping the design at gate-level mux layers.

Verification (WIDTH=32, REG_MASK=5'b00100, latency 2)
REQ-026 SLL of 0x00000001 by 31 -> 0x80000000 with out_valid exactly 2 cycles after acceptance; shamt=0 on all ops -> identity.
REQ-027 SRA of 0x80000000 by 4 -> 0xF8000000; SRL of the same -> 0x08000000.
REQ-028 ROR of 0x000000F1 by 4 -> 0x1000000F; ROL of 0x80000001 by 1 -> 0x00000003.
REQ-029 Send 3 back-to-back ops with tags 1, 2, 3 while out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; on release, tags come out 1, 2, 3 in order with stable data.
REQ-030 Pull rst_n low with 2 ops in flight -> out_valid=0 the same cycle, and no output after release until a new op is accepted.
REQ-031 op=101 with data 0x12345678 -> out_data 0x12345678 and out_err=1; repeat the SLL and ROR tests with WIDTH=8, REG_MASK=3'b000 at latency 1.
